// File: rtl/wide_add_sequencer.sv
// Purpose : multi-precision add/subtract controller that time-shares one external
//           32-bit adder over WORDS cycles, least significant slice first.
// Latency : start accepted at edge 0, RUN on edges 1..WORDS, done pulses in the
//           following cycle (WORDS+1 cycles per op including the DONE cycle).
// Backpressure: none; start is only taken in IDLE or DONE and ignored while busy.
// Ports   : clk/rst (sync active-high), start/sub/op_a/op_b request in,
//           busy/done/result/cout/overflow status out, adder_a/adder_b/adder_cin to
//           the external adder, adder_s/adder_cout back from it (combinational).
module wide_add_sequencer #(
   parameter int WORDS = 4,
   parameter int W     = 32 * WORDS
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          sub,
   input  logic [W-1:0]  op_a,
   input  logic [W-1:0]  op_b,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  result,
   output logic          cout,
   output logic          overflow,
   output logic [31:0]   adder_a,
   output logic [31:0]   adder_b,
   output logic          adder_cin,
   input  logic [31:0]   adder_s,
   input  logic          adder_cout
);

   localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    result_q, result_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;
   logic [IDXW-1:0] idx_q, idx_d;

   // Bit offset of the slice currently being processed.
   logic [IDXW+4:0] slice_lsb;
   assign slice_lsb = {idx_q, 5'd0};

   assign busy     = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);
   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      idx_d     = idx_q;
      adder_a   = 32'd0;
      adder_b   = 32'd0;
      adder_cin = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               // Subtraction is A + ~B + 1: invert B once at capture and seed
               // the carry chain with 1.
               a_d     = op_a;
               b_d     = sub ? ~op_b : op_b;
               carry_d = sub;
               idx_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RUN: begin
            adder_a   = a_q[slice_lsb +: 32];
            adder_b   = b_q[slice_lsb +: 32];
            adder_cin = carry_q;
            result_d[slice_lsb +: 32] = adder_s;
            carry_d   = adder_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = adder_cout;
               // Signed overflow: operands share a sign that the top slice's
               // sum does not. b_q already holds the effective operand.
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (adder_s[31] != a_q[W-1]);
               idx_d   = '0;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         idx_q    <= idx_d;
      end
   end

endmodule
